// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD message path: FSM encoding, idle code and event-to-code mapping.
// Also used by LCD1604_controller's message table.
package lcd_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StShow = 2'd2;

  localparam logic [3:0] LcdIdleMsg = 4'd0;

  // Event index i is displayed as message code i+1; code 0 is reserved for idle.
  function automatic logic [3:0] evt_code(input int idx);
    return 4'(idx + 1);
  endfunction

endpackage

// File: rtl/lcd_msg_scheduler_if.sv
// Event/message bundle between the system event sources and the LCD message scheduler.
interface lcd_msg_scheduler_if #(
  parameter int unsigned NUM_EVT = 8
);
  logic [NUM_EVT-1:0] evt_i;
  logic [3:0]         mensaje;
  logic               ready_o;
  logic               fifo_full_o;
  logic               coalesce_o;

  modport master (
    output evt_i,
    input  mensaje, ready_o, fifo_full_o, coalesce_o
  );

  modport slave (
    input  evt_i,
    output mensaje, ready_o, fifo_full_o, coalesce_o
  );
endinterface

// File: rtl/msg_fifo.sv
// Synchronous circular-buffer FIFO with combinational head read and registered full flag.
module msg_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count, w_count_d;
  logic             r_full;
  logic             w_wr, w_rd;

  // A push into a full buffer is legal when the head is consumed in the same cycle.
  assign w_wr = i_push & (~r_full | i_pop);
  assign w_rd = i_pop & (r_count != '0);

  always_comb begin
    w_count_d = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_d;
      r_full  <= (w_count_d == FullCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;
endmodule

// File: rtl/lcd_msg_scheduler.sv
// Turns event pulses into queued 4-bit message codes, each held on mensaje for a dwell time.
// Optional macro LCD_MSG_DEDUP_EN drops a push that repeats the still-live last pushed code.
module lcd_msg_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_EVT      = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter logic [3:0]  IDLE_MSG     = LcdIdleMsg
) (
  input  logic          clk,
  input  logic          reset,
  lcd_msg_scheduler_if.slave bus
);
  localparam int unsigned TW = $clog2(DWELL_CYCLES);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DepthCnt  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TimerLoad = TW'(DWELL_CYCLES - 1);

  logic [NUM_EVT-1:0] r_pend, w_sel, w_clr;
  logic [3:0]         w_code, w_head;
  logic               w_any, w_grant, w_dup, w_push, w_pop;
  logic [CW-1:0]      w_count;
  logic               w_full;
  logic               r_coalesce;

  logic [1:0]    r_state, w_state_d;
  logic [3:0]    r_msg, w_msg_d;
  logic          r_ready, w_ready_d;
  logic [TW-1:0] r_timer, w_timer_d;

  // Lowest pending index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    w_sel  = '0;
    w_code = '0;
    w_any  = 1'b0;
    for (int i = int'(NUM_EVT) - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
        w_code   = evt_code(i);
        w_any    = 1'b1;
      end
    end
  end

  assign w_pop   = (r_state == StLoad);
  assign w_grant = w_any & ((w_count < DepthCnt) | w_pop);
  assign w_clr   = w_grant ? w_sel : '0;
  assign w_push  = w_grant & ~w_dup;

`ifdef LCD_MSG_DEDUP_EN
  logic [3:0] r_last_code;

  // With an empty queue the last pushed entry is live only while it is being displayed.
  assign w_dup = w_grant & (w_code == r_last_code) & ((w_count != '0) | (r_state == StShow));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_last_code <= IDLE_MSG;
    else if (w_push) r_last_code <= w_code;
  end
`else
  assign w_dup = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend     <= '0;
      r_coalesce <= 1'b0;
    end else begin
      // A fresh event on the bit being pushed re-arms it.
      r_pend     <= (r_pend & ~w_clr) | bus.evt_i;
      r_coalesce <= (|(bus.evt_i & r_pend & ~w_clr)) | w_dup;
    end
  end

  msg_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_code),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_comb begin
    w_state_d = r_state;
    w_msg_d   = r_msg;
    w_ready_d = r_ready;
    w_timer_d = r_timer;
    case (r_state)
      StIdle: begin
        w_msg_d   = IDLE_MSG;
        w_ready_d = 1'b1;
        if (w_count != '0) w_state_d = StLoad;
      end
      StLoad: begin
        w_msg_d   = w_head;
        w_ready_d = 1'b0;
        w_timer_d = TimerLoad;
        w_state_d = StShow;
      end
      StShow: begin
        w_ready_d = 1'b1;
        if (r_timer == '0) begin
          if (w_count != '0) begin
            w_state_d = StLoad;
          end else begin
            w_msg_d   = IDLE_MSG;
            w_ready_d = 1'b0;
            w_state_d = StIdle;
          end
        end else begin
          w_timer_d = r_timer - 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_msg   <= IDLE_MSG;
      r_ready <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_d;
      r_msg   <= w_msg_d;
      r_ready <= w_ready_d;
      r_timer <= w_timer_d;
    end
  end

  assign bus.mensaje     = r_msg;
  assign bus.ready_o     = r_ready;
  assign bus.fifo_full_o = w_full;
  assign bus.coalesce_o  = r_coalesce;
endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Directed bench for lcd_msg_scheduler (DWELL_CYCLES=10, FIFO_DEPTH=4, NUM_EVT=8).
// Expectations follow LCD_MSG_DEDUP_EN when the macro is defined.
module tb_lcd_msg_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   t;

  always #5 clk = ~clk;

  lcd_msg_scheduler_if #(.NUM_EVT(8)) bus ();

  lcd_msg_scheduler #(
    .NUM_EVT      (8),
    .FIFO_DEPTH   (4),
    .DWELL_CYCLES (10),
    .IDLE_MSG     (4'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Drive mask so that it is sampled on edge number e.
  task automatic pulse_at(input int e, input logic [7:0] mask);
    wait_until(e - 1);
    bus.evt_i = mask;
    tick();
    bus.evt_i = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] m, input logic r);
    check({tag, "_mensaje"}, 32'(bus.mensaje), 32'(m));
    check({tag, "_ready"}, 32'(bus.ready_o), 32'(r));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    reset     = 1'b0;
    bus.evt_i = '0;

    // 1: reset values, ready rises one clock after release, idle stays idle
    tick();
    tick();
    check_out("rst", 4'd0, 1'b0);
    check("rst_full", 32'(bus.fifo_full_o), 0);
    check("rst_coal", 32'(bus.coalesce_o), 0);
    reset = 1'b1;
    tick();
    check_out("rel1", 4'd0, 1'b1);
    wait_until(cyc + 10);
    check_out("idle", 4'd0, 1'b1);
    check("idle_full", 32'(bus.fifo_full_o), 0);

    // 2: single event, latency and dwell
    t = cyc + 2;
    pulse_at(t, 8'h04);
    wait_until(t + 1);  check_out("t2_p1", 4'd0, 1'b1);
    wait_until(t + 2);  check_out("t2_p2", 4'd0, 1'b1);
    wait_until(t + 3);  check_out("t2_load", 4'd3, 1'b0);
    wait_until(t + 4);  check_out("t2_show", 4'd3, 1'b1);
    wait_until(t + 12); check_out("t2_last", 4'd3, 1'b1);
    wait_until(t + 13); check_out("t2_end", 4'd0, 1'b0);
    wait_until(t + 14); check_out("t2_idle", 4'd0, 1'b1);

    // 3: three events in one cycle, back-to-back display in index order
    t = cyc + 3;
    pulse_at(t, 8'h83);
    wait_until(t + 3);  check_out("t3_c1", 4'd1, 1'b0);
    wait_until(t + 13); check_out("t3_c1end", 4'd1, 1'b1);
    wait_until(t + 14); check_out("t3_c2", 4'd2, 1'b0);
    wait_until(t + 15); check_out("t3_c2s", 4'd2, 1'b1);
    wait_until(t + 24); check_out("t3_c2end", 4'd2, 1'b1);
    wait_until(t + 25); check_out("t3_c8", 4'd8, 1'b0);
    wait_until(t + 34); check_out("t3_c8end", 4'd8, 1'b1);
    wait_until(t + 35); check_out("t3_idle", 4'd0, 1'b0);
    wait_until(t + 36); check_out("t3_idle2", 4'd0, 1'b1);

    // 4: six events while showing code 1 overflow the queue into pending bits
    t = cyc + 3;
    pulse_at(t, 8'h01);
    wait_until(t + 3);  check_out("t4_c1", 4'd1, 1'b0);
    pulse_at(t + 4, 8'h7E);
    wait_until(t + 7);  check("t4_full_lo", 32'(bus.fifo_full_o), 0);
    wait_until(t + 8);  check("t4_full_hi", 32'(bus.fifo_full_o), 1);
    wait_until(t + 14); check_out("t4_c2", 4'd2, 1'b0);
    check("t4_full_keep", 32'(bus.fifo_full_o), 1);
    wait_until(t + 25); check_out("t4_c3", 4'd3, 1'b0);
    wait_until(t + 35); check("t4_full_last", 32'(bus.fifo_full_o), 1);
    wait_until(t + 36); check_out("t4_c4", 4'd4, 1'b0);
    check("t4_full_drop", 32'(bus.fifo_full_o), 0);
    wait_until(t + 47); check_out("t4_c5", 4'd5, 1'b0);
    wait_until(t + 58); check_out("t4_c6", 4'd6, 1'b0);
    wait_until(t + 69); check_out("t4_c7", 4'd7, 1'b0);
    wait_until(t + 78); check_out("t4_c7end", 4'd7, 1'b1);
    wait_until(t + 79); check_out("t4_idle", 4'd0, 1'b0);

    // 5: event 0 pulsed twice while blocked by a full queue
    t = cyc + 3;
    pulse_at(t, 8'h3E);
    wait_until(t + 3);  check_out("t5_c2", 4'd2, 1'b0);
    wait_until(t + 5);  check("t5_full", 32'(bus.fifo_full_o), 1);
    pulse_at(t + 7, 8'h01);
    wait_until(t + 8);  check("t5_coal_first", 32'(bus.coalesce_o), 0);
    pulse_at(t + 9, 8'h01);
    check("t5_coal_hit", 32'(bus.coalesce_o), 1);
    wait_until(t + 10); check("t5_coal_once", 32'(bus.coalesce_o), 0);
    wait_until(t + 14); check_out("t5_c3", 4'd3, 1'b0);
    wait_until(t + 25); check_out("t5_c4", 4'd4, 1'b0);
    wait_until(t + 36); check_out("t5_c5", 4'd5, 1'b0);
    wait_until(t + 47); check_out("t5_c6", 4'd6, 1'b0);
    wait_until(t + 58); check_out("t5_c1", 4'd1, 1'b0);
    wait_until(t + 67); check_out("t5_c1end", 4'd1, 1'b1);
    wait_until(t + 68); check_out("t5_idle", 4'd0, 1'b0);
    wait_until(t + 80); check_out("t5_noagain", 4'd0, 1'b1);

    // 5b: back-to-back repeat of code 5
    t = cyc + 3;
    pulse_at(t, 8'h10);
    pulse_at(t + 2, 8'h10);
    wait_until(t + 3);  check_out("t5b_c5", 4'd5, 1'b0);
`ifdef LCD_MSG_DEDUP_EN
    check("t5b_coal", 32'(bus.coalesce_o), 1);
    wait_until(t + 13); check_out("t5b_end", 4'd0, 1'b0);
    wait_until(t + 14); check_out("t5b_after", 4'd0, 1'b1);
`else
    check("t5b_coal", 32'(bus.coalesce_o), 0);
    wait_until(t + 13); check_out("t5b_end", 4'd5, 1'b1);
    wait_until(t + 14); check_out("t5b_after", 4'd5, 1'b0);
`endif
    wait_until(t + 30); check_out("t5b_idle", 4'd0, 1'b1);

    // 6: asynchronous reset mid-dwell with three entries queued
    t = cyc + 3;
    pulse_at(t, 8'h0F);
    wait_until(t + 5);  check_out("t6_c1", 4'd1, 1'b1);
    wait_until(t + 6);
    #2 reset = 1'b0;
    #1;
    check_out("t6_async", 4'd0, 1'b0);
    check("t6_full", 32'(bus.fifo_full_o), 0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_out("t6_rel", 4'd0, 1'b1);
    t = cyc;
    wait_until(t + 15); check_out("t6_empty", 4'd0, 1'b1);
    check("t6_full2", 32'(bus.fifo_full_o), 0);
    wait_until(t + 30); check_out("t6_empty2", 4'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/lcd_msg_scheduler.md
Name: lcd_msg_scheduler

Overview:
- Upstream feeder of LCD1604_controller.
- Converts one-cycle system event pulses into 4-bit message codes.
- Queues the codes and presents each on `mensaje` for a minimum dwell time.
- Drives the controller's `ready_i` so each new code is seen on a clean rising edge with data already stable.

Parameters:
- NUM_EVT, 8, number of event inputs (1..15); event i maps to code i+1.
- FIFO_DEPTH, 4, message queue entries (power of 2, ≥2).
- DWELL_CYCLES, 50_000_000, clk cycles each message is held (1 s at 50 MHz); ≥2.
- IDLE_MSG, 4'd0, code shown when the queue is empty.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- evt_i  in  NUM_EVT  event pulses, one bit per event, synchronous to clk.
- mensaje  out  4  message code to LCD1604_controller.
- ready_o  out  1  to controller `ready_i`; low for exactly one cycle whenever `mensaje` changes.
- fifo_full_o  out  1  queue full.
- coalesce_o  out  1  one-cycle pulse: an event arrived while its pending bit was already set.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, mensaje=IDLE_MSG, ready_o=0.
  - Pending bits, FIFO pointers/count, timer and coalesce_o all cleared.
  - First clock after release: ready_o=1.
  - Reset asserted mid-dwell or mid-queue discards everything immediately.
- Pending capture:
  - pend[i] sets on evt_i[i]=1; clears when event i is pushed.
  - evt_i[i] while pend[i]=1 → coalesce_o=1 next cycle; no second entry.
  - Set and clear in the same cycle: set wins, so the new event stays pending.
- Arbiter / push:
  - Each cycle, the lowest-index pending bit is pushed as code (i+1).
  - Push is allowed if count<FIFO_DEPTH, or if a pop occurs the same cycle.
  - At most one push per cycle.
  - When the FIFO is full, pending bits hold; no event is lost.
- FIFO: circular buffer with wrapping read/write pointers. fifo_full_o = (count==FIFO_DEPTH), registered.
- FSM states IDLE, LOAD, SHOW:
  - IDLE: mensaje=IDLE_MSG, ready_o=1. If count≠0 → LOAD.
  - LOAD (1 cycle):
    - Pop the head; mensaje←head; ready_o←0; timer←DWELL_CYCLES-1.
    - → SHOW.
  - SHOW:
    - ready_o=1; timer decrements each cycle.
    - At timer==0: if count≠0 → LOAD; else mensaje←IDLE_MSG, ready_o←0 for one cycle → IDLE.
    - Events never preempt a running dwell.
- Latency: event pulse at cycle t with empty FIFO in IDLE → pushed t+1, LOAD t+2, new mensaje visible t+3 with ready_o=0, ready_o=1 at t+4.
- Timer width: $clog2(DWELL_CYCLES). Count width: $clog2(FIFO_DEPTH)+1.

Optional Feature:
- Macro LCD_MSG_DEDUP_EN.
- Defined:
  - A push is suppressed if its code equals the most recently pushed code and that entry is still queued or displaying.
  - The pending bit is still cleared, and coalesce_o pulses.
- Undefined: duplicates are queued normally.

Decomposition:
- Shared package `lcd_pkg`:
  - FSM state encoding (IDLE/LOAD/SHOW).
  - IDLE_MSG.
  - Message code constants, shared with LCD1604_controller's message table.
- One natural sub-module: `msg_fifo` (sync FIFO, parameters WIDTH=4, DEPTH).
- Arbiter, pending register and FSM stay in the top module.

Test Plan:
All cases use DWELL_CYCLES=10, FIFO_DEPTH=4, NUM_EVT=8.
1. Reset released, no events → mensaje=0 indefinitely; ready_o 0→1 one cycle after release; fifo_full_o=0.
2. Pulse evt_i=8'h04 in IDLE → mensaje=3 three cycles later with ready_o=0 that cycle; held 10 cycles; then mensaje=0 with a one-cycle ready_o low.
3. Pulse evt_i=8'h83 in one cycle → codes 1, 2, 8 displayed in that order, each 10 cycles, no idle gap between them.
4. Six distinct events while showing code 1 → FIFO reaches 4, fifo_full_o=1; remaining two stay pending; all six codes eventually displayed in arbiter order.
5. evt_i[0] pulsed twice before it is pushed → coalesce_o pulses once; code 1 queued once. With LCD_MSG_DEDUP_EN, a back-to-back repeat of code 5 is shown once.
6. Reset asserted mid-SHOW with 3 queued → mensaje=0 and ready_o=0 immediately (async); after release the queue is empty and nothing further is displayed.
